// File: rtl/trig_fifo.sv
// trig_fifo: parametrised synchronous FIFO for the minimum-trigger datapath.
// Occupancy count, programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, and a compile-time choice between
// first-word-fall-through and registered-read output.
module trig_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int AFULL_TH   = 28,
    parameter int AEMPTY_TH  = 4,
    parameter int FWFT       = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  WE,
    input  logic                  RE,
    input  logic                  CLR_ERR,
    output logic [WIDTH-1:0]      DOUT,
    output logic                  DVALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C   = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C  = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_acc;
    logic                  wr_acc;

    // Accept decisions: a read needs data; a write needs room, or a
    // same-cycle accepted read that frees a slot.
    always_comb begin
        rd_acc = RE & (count_q != '0);
        wr_acc = WE & ((count_q != DEPTH_C) | rd_acc);
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (wr_acc) begin
            wp_d = wp_q + 1'b1;
        end
        if (rd_acc) begin
            rp_d = rp_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set has priority over clear when both happen in one cycle.
        ovf_d = (WE & ~wr_acc) | (ovf_q & ~CLR_ERR);
        unf_d = (RE & ~rd_acc) | (unf_q & ~CLR_ERR);
    end

    // Control state register; inputs in the reset cycle are ignored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_acc && !RESET) begin
            mem_q[wp_q] <= DIN;
        end
    end

    // Status flags decode the registered count only.
    always_comb begin
        EMPTY        = (count_q == '0);
        FULL         = (count_q == DEPTH_C);
        ALMOST_EMPTY = (count_q <= AEMPTY_C);
        ALMOST_FULL  = (count_q >= AFULL_C);
        COUNT        = count_q;
        OVERFLOW     = ovf_q;
        UNDERFLOW    = unf_q;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero when nothing is stored.
            always_comb begin
                DOUT   = (count_q != '0) ? mem_q[rp_q] : '0;
                DVALID = (count_q != '0);
            end
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            logic             dvalid_q;

            // Registered read: one-cycle latency, DOUT holds between reads.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem_q[rp_q];
                    end
                end
            end

            always_comb begin
                DOUT   = dout_q;
                DVALID = dvalid_q;
            end
        end
    endgenerate

endmodule
